// File: rtl/debounce_strobe.sv
// ---------------------------------------------------------------------------
// debounce_strobe
//   Conditions one raw, possibly bouncy, asynchronous input for the
//   enable/preset flip-flop stage. A change on din is accepted only after
//   STABLE_CYCLES consecutive identical samples. Each accepted change updates
//   dout and produces a one-cycle strobe on en_out, plus rise/fall qualifiers.
//
//   Configuration macro: DEBOUNCE_SYNC_EN
//     defined   : two-flop synchronizer ahead of the FSM (latency +1 cycle)
//     undefined : single sample flop, din must already be clk-synchronous
//
//   Ports
//     clk     in   posedge clock
//     rst     in   asynchronous, active-high reset
//     din     in   raw input
//     dout    out  debounced level (registered)
//     en_out  out  one-cycle strobe on each accepted change
//     rise    out  one-cycle strobe, accepted change to 1
//     fall    out  one-cycle strobe, accepted change to 0
// ---------------------------------------------------------------------------
module debounce_strobe #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter logic        RESET_VAL     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic en_out,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             dout_nxt;
   logic             en_nxt;
   logic             rise_nxt;
   logic             fall_nxt;
   logic             s;

   // Input sampler; resets to RESET_VAL so release never looks like a change
`ifdef DEBOUNCE_SYNC_EN
   logic sync_meta;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= RESET_VAL;
         sync_q    <= RESET_VAL;
      end else begin
         sync_meta <= din;
         sync_q    <= sync_meta;
      end
   end
`else
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= RESET_VAL;
      end else begin
         sync_q <= din;
      end
   end
`endif

   assign s = sync_q;

   // State, counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_STABLE;
         cnt    <= '0;
         dout   <= RESET_VAL;
         en_out <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         dout   <= dout_nxt;
         en_out <= en_nxt;
         rise   <= rise_nxt;
         fall   <= fall_nxt;
      end
   end

   // Next-state: count consecutive samples that differ from the current level
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dout_nxt  = dout;
      en_nxt    = 1'b0;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;

      case (state)
         ST_STABLE: begin
            if (s != dout) begin
               state_nxt = ST_CHECK;
               cnt_nxt   = CNT_W'(1);
            end else begin
               cnt_nxt   = '0;
            end
         end
         ST_CHECK: begin
            if (s == dout) begin
               // Glitch: sample fell back before the run completed
               state_nxt = ST_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_STABLE;
               cnt_nxt   = '0;
               dout_nxt  = s;
               en_nxt    = 1'b1;
               rise_nxt  = s;
               fall_nxt  = ~s;
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_debounce_strobe.sv
// ---------------------------------------------------------------------------
// tb_debounce_strobe
//   Directed bench for debounce_strobe at default parameters. Stimulus is
//   driven on negedge and outputs are sampled on negedge. Latency adapts to
//   DEBOUNCE_SYNC_EN. A history-window reference checks a random phase.
// ---------------------------------------------------------------------------
module tb_debounce_strobe;

`ifdef DEBOUNCE_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 1;
`endif
   localparam int LAT = 4 + SYNC - 1;

   logic clk_tb;
   logic rst;
   logic din;
   logic dout;
   logic en_out;
   logic rise;
   logic fall;

   int n_checks = 0;
   int n_fail   = 0;

   debounce_strobe dut (
      .clk    (clk_tb),
      .rst    (rst),
      .din    (din),
      .dout   (dout),
      .en_out (en_out),
      .rise   (rise),
      .fall   (fall)
   );

   initial clk_tb = 1'b0;
   always #10 clk_tb = ~clk_tb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] hist;
      logic [3:0] win;
      logic       mdout;
      logic       acc;
      logic       rdin;
      int         run_left;
      logic [5:0] seq4;

      // Test 1: async reset, then quiet input
      rst = 1'b1;
      din = 1'b0;
      #1;
      check("t1_rst_dout", 32'(dout), 32'd1);
      check("t1_rst_en", 32'(en_out), 32'd0);
      check("t1_rst_cnt", 32'(dut.cnt), 32'd0);
      @(negedge clk_tb);
      check("t1_rst_hold_en", 32'(en_out), 32'd0);
      @(negedge clk_tb);
      rst = 1'b0;
      din = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_tb);
         check("t1_quiet_en", 32'(en_out), 32'd0);
      end
      check("t1_quiet_dout", 32'(dout), 32'd1);

      // Test 2: accepted fall after LAT edges
      din = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_tb);
         check("t2_dout", 32'(dout), (k >= LAT) ? 32'd0 : 32'd1);
         check("t2_en", 32'(en_out), (k == LAT) ? 32'd1 : 32'd0);
         check("t2_fall", 32'(fall), (k == LAT) ? 32'd1 : 32'd0);
         check("t2_rise", 32'(rise), 32'd0);
      end

      // Back to 1: accepted rise
      din = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_tb);
         check("t2b_dout", 32'(dout), (k >= LAT) ? 32'd1 : 32'd0);
         check("t2b_rise", 32'(rise), (k == LAT) ? 32'd1 : 32'd0);
         check("t2b_fall", 32'(fall), 32'd0);
      end

      // Test 3: 3-cycle 0 pulse is rejected
      for (int k = 0; k < 12; k++) begin
         din = (k < 3) ? 1'b0 : 1'b1;
         @(negedge clk_tb);
         check("t3_dout", 32'(dout), 32'd1);
         check("t3_en", 32'(en_out), 32'd0);
         check("t3_rise", 32'(rise), 32'd0);
         check("t3_fall", 32'(fall), 32'd0);
      end

      // Test 4: bounce 0,1 then a run of 0s; strobe LAT edges after run start
      seq4 = 6'b000010;
      for (int j = 0; j < 10; j++) begin
         din = (j < 6) ? seq4[j] : 1'b0;
         @(negedge clk_tb);
         check("t4_dout", 32'(dout), (j >= 2 + LAT) ? 32'd0 : 32'd1);
         check("t4_en", 32'(en_out), (j == 2 + LAT) ? 32'd1 : 32'd0);
         check("t4_fall", 32'(fall), (j == 2 + LAT) ? 32'd1 : 32'd0);
      end
      din = 1'b1;
      for (int k = 0; k < 10; k++) @(negedge clk_tb);
      check("t4_restore_dout", 32'(dout), 32'd1);

      // Test 5: reset in the middle of a count
      din = 1'b0;
      for (int k = 0; k <= LAT - 2; k++) @(negedge clk_tb);
      check("t5_cnt_before", 32'(dut.cnt), 32'd2);
      rst = 1'b1;
      #1;
      check("t5_rst_dout", 32'(dout), 32'd1);
      check("t5_rst_cnt", 32'(dut.cnt), 32'd0);
      check("t5_rst_en", 32'(en_out), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_tb);
         check("t5_rst_hold_en", 32'(en_out), 32'd0);
      end
      rst = 1'b0;
      din = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_tb);
         check("t5_post_en", 32'(en_out), 32'd0);
         check("t5_post_dout", 32'(dout), 32'd1);
      end

      // Test 6: random runs against a sample-history reference
      hist     = 8'hFF;
      mdout    = 1'b1;
      run_left = 0;
      rdin     = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (run_left == 0) begin
            rdin     = 1'($urandom_range(0, 1));
            run_left = int'($urandom_range(1, 6));
         end
         run_left--;
         din = rdin;
         @(negedge clk_tb);
         hist = {hist[6:0], rdin};
         win  = hist[SYNC +: 4];
         acc  = (win == {4{~mdout}});
         if (acc) mdout = ~mdout;
         check("t6_dout", 32'(dout), 32'(mdout));
         check("t6_en", 32'(en_out), 32'(acc));
         check("t6_rise", 32'(rise), 32'(acc & mdout));
         check("t6_fall", 32'(fall), 32'(acc & ~mdout));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
